shop_token_rx: RTL

- Upstream front end of the shop command processor.
- Accepts a byte stream of ASCII characters (terminal/UART side) over a valid/ready handshake and assembles each whitespace-delimited token into a right-justified packed ASCII word, matching how Verilog string literals such as "Logout" pack.
- Presents the word on o_a with a one-cycle o_rdy strobe. When the token is all digits, it also presents its saturated numeric value on o_u.

---
 rtl/shop_pkg.sv | 36 +++
 rtl/shop_dec_acc.sv | 92 +++++++++
 rtl/shop_token_rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/shop_pkg.sv
// ---------------------------------------------------------------------------
// shop_pkg
// Shared definitions for the shop command processor front end.
//   - ASCII byte constants used by the token receiver
//   - Token FSM state encoding (IDLE, ACCUM, DISCARD, EMIT)
//   - CMD_KEY__* packed command keys, right-justified the same way a Verilog
//     string literal packs, so they compare directly against o_a
// ---------------------------------------------------------------------------
package shop_pkg;

    localparam logic [7:0] ASCII_SP       = 8'h20;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_0        = 8'h30;
    localparam logic [7:0] ASCII_9        = 8'h39;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h21;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;
    localparam logic [1:0] EMIT    = 2'd3;

    localparam logic [55:0] CMD_KEY__LOGIN    = 56'h00_00_4C_6F_67_69_6E;
    localparam logic [55:0] CMD_KEY__LOGOUT   = 56'h00_4C_6F_67_6F_75_74;
    localparam logic [55:0] CMD_KEY__ADD_ITEM = 56'h41_64_64_49_74_65_6D;
    localparam logic [55:0] CMD_KEY__BUY      = 56'h00_00_00_00_42_75_79;
    localparam logic [55:0] CMD_KEY__ADM      = 56'h00_00_00_00_41_64_6D;
    localparam logic [55:0] CMD_KEY__DEL      = 56'h00_00_00_00_44_65_6C;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/shop_dec_acc.sv
// ---------------------------------------------------------------------------
// shop_dec_acc
// Saturating decimal accumulator for one token. The value is clamped at
// 2^U_NUM_BITS so that "greater than the output range" stays detectable
// without the register growing. A non-digit character clears is_num.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   clr_i            clear: acc=0, is_num=1 (highest priority)
//   bs_i             recompute from bs_word_i / bs_cnt_i (remaining chars)
//   chr_vld_i, chr_i one character appended to the token
//   acc_o, is_num_o  current accumulator value and all-digits flag
// ---------------------------------------------------------------------------
module shop_dec_acc
    import shop_pkg::*;
#(
    parameter int MAX_CHARS  = 7,
    parameter int U_NUM_BITS = 4,
    parameter int ACC_W      = U_NUM_BITS + 4,
    parameter int CNT_W      = $clog2(MAX_CHARS + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   clr_i,
    input  logic                   bs_i,
    input  logic [MAX_CHARS*8-1:0] bs_word_i,
    input  logic [CNT_W-1:0]       bs_cnt_i,
    input  logic                   chr_vld_i,
    input  logic [7:0]             chr_i,
    output logic [ACC_W-1:0]       acc_o,
    output logic                   is_num_o
);

    localparam logic [ACC_W-1:0] ACC_CAP = ACC_W'(1 << U_NUM_BITS);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             is_num_q, is_num_d;

    function automatic logic [ACC_W-1:0] mac10(input logic [ACC_W-1:0] a,
                                               input logic [7:0]       c);
        logic [ACC_W+3:0] t;
        t = ({4'b0, a} * (ACC_W+4)'(10)) + (ACC_W+4)'(4'(c - ASCII_0));
        if (t > {4'b0, ACC_CAP}) return ACC_CAP;
        return t[ACC_W-1:0];
    endfunction

    // Re-derives the value of the first n characters of a right-justified
    // word, oldest character first.
    function automatic logic [ACC_W:0] recompute(input logic [MAX_CHARS*8-1:0] w,
                                                 input logic [CNT_W-1:0]       n);
        logic [ACC_W-1:0] a;
        logic             num;
        logic [7:0]       c;
        a   = '0;
        num = 1'b1;
        for (int i = MAX_CHARS - 1; i >= 0; i--) begin
            if (i < int'(n)) begin
                c = w[i*8 +: 8];
                if (is_digit(c)) a = mac10(a, c);
                else             num = 1'b0;
            end
        end
        return {num, a};
    endfunction

    always_comb begin
        acc_d    = acc_q;
        is_num_d = is_num_q;
        if (clr_i) begin
            acc_d    = '0;
            is_num_d = 1'b1;
        end else if (bs_i) begin
            {is_num_d, acc_d} = recompute(bs_word_i, bs_cnt_i);
        end else if (chr_vld_i) begin
            if (is_digit(chr_i)) acc_d    = mac10(acc_q, chr_i);
            else                 is_num_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc_q    <= '0;
            is_num_q <= 1'b1;
        end else begin
            acc_q    <= acc_d;
            is_num_q <= is_num_d;
        end
    end

    assign acc_o    = acc_q;
    assign is_num_o = is_num_q;

endmodule

// File: rtl/shop_token_rx.sv
// ---------------------------------------------------------------------------
// shop_token_rx
// Assembles whitespace-delimited ASCII tokens from a valid/ready byte stream
// into a right-justified packed word, plus a saturated decimal value when the
// token is all digits.
// Optional feature macro: SHOP_TOKEN_BACKSPACE_EN (0x08 erases the last
// character of the token being assembled; otherwise 0x08 is a bad character).
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_valid, i_data  input byte and its valid; transfers when o_ready is high
//   o_ready          low only during the single EMIT cycle
//   o_rdy            one-cycle strobe: o_a/o_u/o_is_num/o_num_sat are new
//   o_a              packed token, zero-filled MSBs
//   o_u, o_is_num    saturated decimal value, all-digits flag
//   o_num_sat        numeric value was clamped
//   o_ovf            one-cycle strobe: token longer than MAX_CHARS
//   o_bad_char       one-cycle strobe: non-printable, non-delimiter byte
// ---------------------------------------------------------------------------
module shop_token_rx
    import shop_pkg::*;
#(
    parameter int MAX_CHARS  = 7,
    parameter int A_NUM_BITS = MAX_CHARS * 8,
    parameter int U_NUM_BITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [7:0]            i_data,
    output logic                  o_ready,
    output logic                  o_rdy,
    output logic [A_NUM_BITS-1:0] o_a,
    output logic [U_NUM_BITS-1:0] o_u,
    output logic                  o_is_num,
    output logic                  o_num_sat,
    output logic                  o_ovf,
    output logic                  o_bad_char
);

    localparam int CNT_W = $clog2(MAX_CHARS + 1);
    localparam int ACC_W = U_NUM_BITS + 4;
    localparam logic [ACC_W-1:0] U_MAX = ACC_W'((1 << U_NUM_BITS) - 1);

    logic [1:0]            state_q, state_d;
    logic [A_NUM_BITS-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [A_NUM_BITS-1:0] a_q;
    logic [U_NUM_BITS-1:0] u_q;
    logic                  is_num_q, num_sat_q, rdy_q, ovf_q, bad_q;

    logic emit_d, ovf_d, bad_d;
    logic acc_clr, acc_bs, acc_chr_vld;
    logic [ACC_W-1:0] acc;
    logic             acc_is_num;

    logic xfer, is_delim, is_print;

    assign o_ready  = (state_q != EMIT);
    assign xfer     = i_valid && o_ready;
    assign is_delim = (i_data == ASCII_SP) || (i_data == ASCII_CR) || (i_data == ASCII_LF);
    assign is_print = (i_data >= ASCII_PRINT_LO) && (i_data <= ASCII_PRINT_HI);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        emit_d      = 1'b0;
        ovf_d       = 1'b0;
        bad_d       = 1'b0;
        acc_clr     = 1'b0;
        acc_bs      = 1'b0;
        acc_chr_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (is_print) begin
                        sr_d        = A_NUM_BITS'(i_data);
                        cnt_d       = CNT_W'(1);
                        acc_chr_vld = 1'b1;
                        state_d     = ACCUM;
                    end else if (is_delim) begin
                        state_d = IDLE;
`ifdef SHOP_TOKEN_BACKSPACE_EN
                    end else if (i_data == ASCII_BS) begin
                        state_d = IDLE;
`endif
                    end else begin
                        bad_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
            end
            ACCUM: begin
                if (xfer) begin
                    if (is_print && (cnt_q < CNT_W'(MAX_CHARS))) begin
                        sr_d        = {sr_q[A_NUM_BITS-9:0], i_data};
                        cnt_d       = cnt_q + CNT_W'(1);
                        acc_chr_vld = 1'b1;
                    end else if (is_delim) begin
                        // Token is latched into the output registers on this
                        // edge, so the working state can be cleared right away.
                        emit_d  = 1'b1;
                        sr_d    = '0;
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                        state_d = EMIT;
`ifdef SHOP_TOKEN_BACKSPACE_EN
                    end else if (i_data == ASCII_BS) begin
                        sr_d    = sr_q >> 8;
                        cnt_d   = cnt_q - CNT_W'(1);
                        acc_bs  = 1'b1;
                        if (cnt_q == CNT_W'(1)) state_d = IDLE;
`endif
                    end else begin
                        ovf_d   = is_print;
                        bad_d   = !is_print;
                        sr_d    = '0;
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (xfer && is_delim) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    shop_dec_acc #(
        .MAX_CHARS (MAX_CHARS),
        .U_NUM_BITS(U_NUM_BITS),
        .ACC_W     (ACC_W),
        .CNT_W     (CNT_W)
    ) u_acc (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .clr_i    (acc_clr),
        .bs_i     (acc_bs),
        .bs_word_i(sr_q >> 8),
        .bs_cnt_i (cnt_q - CNT_W'(1)),
        .chr_vld_i(acc_chr_vld),
        .chr_i    (i_data),
        .acc_o    (acc),
        .is_num_o (acc_is_num)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            u_q       <= '0;
            is_num_q  <= 1'b0;
            num_sat_q <= 1'b0;
            rdy_q     <= 1'b0;
            ovf_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            rdy_q   <= emit_d;
            ovf_q   <= ovf_d;
            bad_q   <= bad_d;
            if (emit_d) begin
                a_q       <= sr_q;
                is_num_q  <= acc_is_num;
                num_sat_q <= acc_is_num && (acc > U_MAX);
                if (!acc_is_num)      u_q <= '0;
                else if (acc > U_MAX) u_q <= '1;
                else                  u_q <= acc[U_NUM_BITS-1:0];
            end
        end
    end

    assign o_rdy      = rdy_q;
    assign o_a        = a_q;
    assign o_u        = u_q;
    assign o_is_num   = is_num_q;
    assign o_num_sat  = num_sat_q;
    assign o_ovf      = ovf_q;
    assign o_bad_char = bad_q;

endmodule
